// File: rtl/reg_scoreboard.sv
// In-flight write scoreboard for the 32-entry integer register file.
// Raises the ID stall on load-use and WAW-counter-full hazards, and reports idle and sticky error.
module reg_scoreboard #(
  parameter int REG_NUM = 32,
  parameter int ADDR_W  = 5,
  parameter int CNT_W   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid,
  input  logic              issue_we,
  input  logic              issue_is_load,
  input  logic [ADDR_W-1:0] issue_rd,
  input  logic              use_rs1,
  input  logic [ADDR_W-1:0] issue_rs1,
  input  logic              use_rs2,
  input  logic [ADDR_W-1:0] issue_rs2,
  input  logic              flush,
  input  logic              ld_done_valid,
  input  logic [ADDR_W-1:0] ld_done_rd,
  input  logic              wb_enable,
  input  logic [ADDR_W-1:0] wb_addr,
  output logic              stall,
  output logic              idle,
  output logic              err
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] r_pend_cnt [REG_NUM];
  logic [CNT_W-1:0] r_ld_cnt   [REG_NUM];
  logic             r_idle;
  logic             r_err;

  logic [CNT_W-1:0] w_pend_nxt [REG_NUM];
  logic [CNT_W-1:0] w_ld_nxt   [REG_NUM];
  logic             w_pend_err [REG_NUM];
  logic             w_ld_err   [REG_NUM];
  logic             w_byp1, w_byp2;
  logic             w_haz1, w_haz2, w_waw;
  logic             w_stall, w_fire;
  logic             w_err_set, w_idle_nxt;

  // Saturating counter step; the top bit flags an under/overflow attempt.
  function automatic logic [CNT_W:0] cnt_step(input logic [CNT_W-1:0] cnt,
                                              input logic inc, input logic dec);
    logic [CNT_W:0] res;
    res = {1'b0, cnt};
    if (inc && !dec) begin
      if (cnt == CNT_MAX) res = {1'b1, cnt};
      else                res = {1'b0, cnt + CNT_ONE};
    end else if (dec && !inc) begin
      if (cnt == '0) res = {1'b1, cnt};
      else           res = {1'b0, cnt - CNT_ONE};
    end else begin
      res = {1'b0, cnt};
    end
    return res;
  endfunction

  // Load still outstanding after removing one completing this very cycle.
  function automatic logic ld_pending(input logic [CNT_W-1:0] cnt, input logic byp);
    return (cnt != '0) && !(byp && (cnt == CNT_ONE));
  endfunction

  // Hazard detection and issue qualification.
  always_comb begin
    w_byp1  = ld_done_valid && (ld_done_rd == issue_rs1);
    w_byp2  = ld_done_valid && (ld_done_rd == issue_rs2);
    w_haz1  = use_rs1 && (issue_rs1 != '0) && ld_pending(r_ld_cnt[issue_rs1], w_byp1);
    w_haz2  = use_rs2 && (issue_rs2 != '0) && ld_pending(r_ld_cnt[issue_rs2], w_byp2);
    w_waw   = issue_we && (issue_rd != '0) && (r_pend_cnt[issue_rd] == CNT_MAX);
    w_stall = issue_valid && !flush && (w_haz1 || w_haz2 || w_waw);
    w_fire  = issue_valid && !flush && !w_stall;
  end

  // Per-register next counts; x0 is never tracked.
  always_comb begin
    for (int r = 0; r < REG_NUM; r++) begin
      w_pend_nxt[r] = '0;
      w_ld_nxt[r]   = '0;
      w_pend_err[r] = 1'b0;
      w_ld_err[r]   = 1'b0;
      if (r != 0) begin
        {w_pend_err[r], w_pend_nxt[r]} = cnt_step(r_pend_cnt[r],
            w_fire && issue_we && (issue_rd == ADDR_W'(r)),
            wb_enable && (wb_addr == ADDR_W'(r)));
        {w_ld_err[r], w_ld_nxt[r]} = cnt_step(r_ld_cnt[r],
            w_fire && issue_we && issue_is_load && (issue_rd == ADDR_W'(r)),
            ld_done_valid && (ld_done_rd == ADDR_W'(r)));
      end else begin
        w_pend_nxt[r] = '0;
        w_ld_nxt[r]   = '0;
      end
    end
  end

  // Reduce next-state counts into idle and error-set flags.
  always_comb begin
    w_err_set  = 1'b0;
    w_idle_nxt = 1'b1;
    for (int r = 0; r < REG_NUM; r++) begin
      w_err_set  = w_err_set | w_pend_err[r] | w_ld_err[r];
      w_idle_nxt = w_idle_nxt & (w_pend_nxt[r] == '0) & (w_ld_nxt[r] == '0);
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < REG_NUM; r++) begin
        r_pend_cnt[r] <= '0;
        r_ld_cnt[r]   <= '0;
      end
      r_idle <= 1'b1;
      r_err  <= 1'b0;
    end else begin
      for (int r = 0; r < REG_NUM; r++) begin
        r_pend_cnt[r] <= w_pend_nxt[r];
        r_ld_cnt[r]   <= w_ld_nxt[r];
      end
      r_idle <= w_idle_nxt;
      r_err  <= r_err | w_err_set;
    end
  end

  assign stall = w_stall;
  assign idle  = r_idle;
  assign err   = r_err;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: directed scenarios plus randomized traffic
// compared against an integer-array reference model.
module tb_reg_scoreboard;

  localparam int REG_NUM = 32;
  localparam int ADDR_W  = 5;
  localparam int CNT_W   = 2;
  localparam int MAXC    = (1 << CNT_W) - 1;

  logic              clk;
  logic              rst;
  logic              issue_valid, issue_we, issue_is_load;
  logic [ADDR_W-1:0] issue_rd, issue_rs1, issue_rs2;
  logic              use_rs1, use_rs2, flush;
  logic              ld_done_valid;
  logic [ADDR_W-1:0] ld_done_rd;
  logic              wb_enable;
  logic [ADDR_W-1:0] wb_addr;
  logic              stall, idle, err;

  int m_pend [REG_NUM];
  int m_ld   [REG_NUM];
  bit m_err;
  int n_chk;
  int n_fail;

  reg_scoreboard #(.REG_NUM(REG_NUM), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_we(issue_we), .issue_is_load(issue_is_load),
    .issue_rd(issue_rd), .use_rs1(use_rs1), .issue_rs1(issue_rs1),
    .use_rs2(use_rs2), .issue_rs2(issue_rs2), .flush(flush),
    .ld_done_valid(ld_done_valid), .ld_done_rd(ld_done_rd),
    .wb_enable(wb_enable), .wb_addr(wb_addr),
    .stall(stall), .idle(idle), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic got, input logic exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  function automatic bit src_waits(input logic use_rs, input logic [ADDR_W-1:0] rs);
    int eff;
    eff = m_ld[rs] - ((ld_done_valid && ld_done_rd == rs) ? 1 : 0);
    return use_rs && (rs != 0) && (eff > 0);
  endfunction

  function automatic bit model_stall();
    bit waw;
    waw = issue_we && (issue_rd != 0) && (m_pend[issue_rd] == MAXC);
    return issue_valid && !flush && (src_waits(use_rs1, issue_rs1) ||
                                     src_waits(use_rs2, issue_rs2) || waw);
  endfunction

  function automatic bit model_idle();
    for (int r = 0; r < REG_NUM; r++)
      if (m_pend[r] != 0 || m_ld[r] != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_update(input bit s);
    bit fire, ip, dp, il, dl;
    if (rst) begin
      for (int r = 0; r < REG_NUM; r++) begin m_pend[r] = 0; m_ld[r] = 0; end
      m_err = 1'b0;
    end else begin
      fire = issue_valid && !flush && !s;
      for (int r = 1; r < REG_NUM; r++) begin
        ip = fire && issue_we && (issue_rd == r);
        dp = wb_enable && (wb_addr == r);
        il = ip && issue_is_load;
        dl = ld_done_valid && (ld_done_rd == r);
        if (ip && !dp) begin if (m_pend[r] == MAXC) m_err = 1'b1; else m_pend[r]++; end
        if (dp && !ip) begin if (m_pend[r] == 0) m_err = 1'b1; else m_pend[r]--; end
        if (il && !dl) begin if (m_ld[r] == MAXC) m_err = 1'b1; else m_ld[r]++; end
        if (dl && !il) begin if (m_ld[r] == 0) m_err = 1'b1; else m_ld[r]--; end
      end
    end
  endtask

  // One clock: check stall before the edge, idle/err after it. exp_stall<0 means model only.
  task automatic step(input bit do_stall, input int exp_stall);
    bit s;
    #1;
    s = model_stall();
    if (do_stall) chk("stall", stall, s);
    if (exp_stall >= 0) chk("stall_directed", stall, exp_stall[0]);
    model_update(s);
    @(posedge clk);
    #1;
    chk("idle", idle, model_idle());
    chk("err", err, m_err);
  endtask

  task automatic clear_in();
    issue_valid = 1'b0; issue_we = 1'b0; issue_is_load = 1'b0; issue_rd = '0;
    use_rs1 = 1'b0; issue_rs1 = '0; use_rs2 = 1'b0; issue_rs2 = '0; flush = 1'b0;
    ld_done_valid = 1'b0; ld_done_rd = '0; wb_enable = 1'b0; wb_addr = '0;
  endtask

  task automatic issue(input logic we, input logic ld, input int rd);
    issue_valid = 1'b1; issue_we = we; issue_is_load = ld; issue_rd = ADDR_W'(rd);
  endtask

  task automatic do_reset();
    clear_in();
    rst = 1'b1;
    step(1'b0, -1);
    rst = 1'b0;
  endtask

  initial begin
    int r, w;
    n_chk = 0; n_fail = 0; m_err = 1'b0;
    for (int i = 0; i < REG_NUM; i++) begin m_pend[i] = 0; m_ld[i] = 0; end
    rst = 1'b0;
    clear_in();
    do_reset();
    chk("reset_idle", idle, 1'b1);
    chk("reset_err", err, 1'b0);

    // ADDI x5 then WB two cycles later
    issue(1'b1, 1'b0, 5); step(1'b1, 0);
    chk("addi_idle_low", idle, 1'b0);
    clear_in(); step(1'b1, 0);
    wb_enable = 1'b1; wb_addr = 5'd5; step(1'b1, 0);
    chk("addi_idle_back", idle, 1'b1);

    // Load-use on x6 with same-cycle bypass
    clear_in(); issue(1'b1, 1'b1, 6); step(1'b1, 0);
    clear_in(); issue(1'b1, 1'b0, 10); use_rs1 = 1'b1; issue_rs1 = 5'd6;
    step(1'b1, 1);
    step(1'b1, 1);
    ld_done_valid = 1'b1; ld_done_rd = 5'd6; step(1'b1, 0);
    clear_in(); wb_enable = 1'b1; wb_addr = 5'd6; step(1'b1, 0);
    chk("lu_not_idle", idle, 1'b0);
    wb_addr = 5'd10; step(1'b1, 0);
    chk("lu_drained", idle, 1'b1);

    // WAW counter full on x7
    clear_in();
    for (int i = 0; i < 3; i++) begin issue(1'b1, 1'b0, 7); step(1'b1, 0); end
    wb_enable = 1'b1; wb_addr = 5'd7; step(1'b1, 1);
    wb_enable = 1'b0; step(1'b1, 0);
    clear_in(); wb_enable = 1'b1; wb_addr = 5'd7;
    for (int i = 0; i < 3; i++) step(1'b1, 0);
    chk("waw_drained", idle, 1'b1);
    chk("waw_err", err, 1'b0);

    // Issue and WB of x9 in the same cycle
    clear_in(); issue(1'b1, 1'b0, 9); step(1'b1, 0);
    wb_enable = 1'b1; wb_addr = 5'd9; step(1'b1, 0);
    clear_in(); step(1'b1, 0);
    chk("x9_still_pending", idle, 1'b0);
    wb_enable = 1'b1; wb_addr = 5'd9; step(1'b1, 0);
    chk("x9_drained", idle, 1'b1);
    chk("x9_err", err, 1'b0);

    // x0 is never tracked
    clear_in(); issue(1'b1, 1'b1, 0); step(1'b1, 0);
    chk("x0_idle", idle, 1'b1);
    clear_in(); issue(1'b1, 1'b0, 0); use_rs1 = 1'b1; issue_rs1 = 5'd0; step(1'b1, 0);

    // Flush squashes, then WB underflow sets sticky err
    clear_in(); issue(1'b1, 1'b0, 4); flush = 1'b1; step(1'b1, 0);
    chk("flush_idle", idle, 1'b1);
    clear_in(); wb_enable = 1'b1; wb_addr = 5'd3; step(1'b1, 0);
    chk("underflow_err", err, 1'b1);
    clear_in(); step(1'b1, 0);
    chk("err_sticky", err, 1'b1);
    do_reset();
    chk("err_cleared", err, 1'b0);

    // Randomized traffic on x0..x7 with periodic mid-run reset
    for (int n = 0; n < 600; n++) begin
      if (n % 150 == 149) begin
        do_reset();
      end else begin
        clear_in();
        issue_valid   = ($urandom_range(0, 3) != 0);
        issue_we      = ($urandom_range(0, 3) != 0);
        issue_is_load = ($urandom_range(0, 2) == 0);
        issue_rd      = ADDR_W'($urandom_range(0, 7));
        use_rs1       = ($urandom_range(0, 1) != 0);
        issue_rs1     = ADDR_W'($urandom_range(0, 7));
        use_rs2       = ($urandom_range(0, 1) != 0);
        issue_rs2     = ADDR_W'($urandom_range(0, 7));
        flush         = ($urandom_range(0, 9) == 0);
        r = int'($urandom_range(1, 7));
        ld_done_valid = (m_ld[r] > 0) && ($urandom_range(0, 1) != 0);
        ld_done_rd    = ADDR_W'(r);
        w = int'($urandom_range(0, 7));
        wb_enable     = ((m_pend[w] > 0) && ($urandom_range(0, 1) != 0)) ||
                        ($urandom_range(0, 39) == 0);
        wb_addr       = ADDR_W'(w);
        step(1'b1, -1);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
- Tracks in-flight writes to the 32-entry integer register file between ID issue and WB retirement.
- Sits beside the ID stage and drives the ID stall for load-use hazards and for write-after-write counter overflow.
- Receives issue events from ID, load-data-ready events from MEM and write events from MEM/WB.
- Reports pipeline idle for fence/drain logic.

Parameters:
REG_NUM, 32, number of architectural registers
ADDR_W, 5, register address width
CNT_W, 2, width of the per-register in-flight counter (maximum 2^CNT_W-1 outstanding writes per register)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
issue_valid  in  1  ID presents an instruction this cycle
issue_we  in  1  instruction writes rd
issue_is_load  in  1  instruction is a load
issue_rd  in  ADDR_W  destination register
use_rs1  in  1  instruction reads rs1
issue_rs1  in  ADDR_W  source 1 address
use_rs2  in  1  instruction reads rs2
issue_rs2  in  ADDR_W  source 2 address
flush  in  1  squash the instruction in ID this cycle
ld_done_valid  in  1  load data is available for forwarding (MEM stage)
ld_done_rd  in  ADDR_W  destination of the completed load
wb_enable  in  1  register-file write this cycle
wb_addr  in  ADDR_W  register-file write address
stall  out  1  hold ID, combinational
idle  out  1  all counters zero, registered
err  out  1  sticky counter under/overflow, registered

Behaviour:
- Reset is `rst` (synchronous, active-high); the clock is `clk`.
- Reset: all pend_cnt[r] and ld_cnt[r] go to 0; idle=1; err=0. A reset in mid-operation discards all tracking in the same edge.
- Register x0 is never tracked:
  - rd=0 does not increment.
  - wb_addr=0 does not decrement.
  - rs=0 never stalls.

Issue and stall:
- fire = issue_valid & !stall & !flush.
- ld_eff[r] = ld_cnt[r] - (ld_done_valid & ld_done_rd==r). This bypass means a load completing in the current cycle does not stall its consumer.
- stall = issue_valid & !flush & (haz1 | haz2 | waw).
  - haz1 = use_rs1 & rs1!=0 & ld_eff[rs1]!=0.
  - haz2 is the same check for rs2.
  - waw = issue_we & rd!=0 & pend_cnt[rd]==max.
- stall is purely combinational from inputs and state, so there is no latency.

Counter updates (per register r, at the clock edge):
- inc_p = fire & issue_we & rd==r & r!=0.
- dec_p = wb_enable & wb_addr==r & r!=0.
- pend_cnt[r]:
  - +1 on inc_p only.
  - -1 on dec_p only.
  - unchanged when both occur in the same cycle.
- inc_l = inc_p & issue_is_load.
- dec_l = ld_done_valid & ld_done_rd==r & r!=0.
- ld_cnt[r] follows the same rules with inc_l/dec_l.
- Overflow and underflow protection:
  - A decrement at 0 sets err and leaves the count at 0.
  - An increment at max cannot occur (waw stalls it). If forced anyway, it sets err and the count saturates.
- err clears only on rst.

Idle:
- idle is registered. It reflects the next-state values, so it rises in the same edge in which the last counter reaches 0.
- idle = 1 iff every pend_cnt and ld_cnt is 0.

Flush:
- Cancels only the current ID instruction, which produces no increment.
- Instructions already issued still retire through WB, so flush does not touch the counters.
- A stall is never asserted while flush=1.

Simultaneous events:
- An issue of rd=r, a WB of r and an ld_done of r can all occur in one cycle. Each counter nets independently.

Test Plan:
- Reset, then ADDI x5 issue (we=1, load=0), WB x5 two cycles later.
  - pend_cnt[5] goes 0→1→0.
  - stall stays 0 throughout.
  - idle goes 1→0→1.
- LW x6 issue, next cycle ADD reads rs1=x6.
  - stall=1 while ld_cnt[6]=1.
  - In the cycle ld_done_valid=1, ld_done_rd=6, stall=0 (bypass) and the ADD fires.
- Three back-to-back writes to x7 with no WB.
  - pend_cnt[7]=3.
  - A fourth issue with rd=7 gives stall=1.
  - A WB of x7 in that cycle keeps stall=1 (the count is registered). The next cycle stall=0.
- Issue rd=9 and WB x9 in the same cycle with pend_cnt[9]=1.
  - The count stays 1.
  - err=0.
- LW x0, then a use of rs1=x0.
  - No counters change.
  - stall=0.
- WB x3 with pend_cnt[3]=0.
  - err=1 next cycle and stays 1.
  - rst clears it.
  - Separately, issue_valid with flush=1 and rd=4 leaves pend_cnt[4]=0 and stall=0.
